// File: rtl/clut_cache_loader_if.sv
// Load-request, VRAM block-read and CLUT write buses of the CLUT cache loader.
// The loader connects through the slave modport; the pipeline/memory side uses master.
interface clut_cache_loader_if;
    logic        load_req;
    logic [5:0]  load_clutX;
    logic [8:0]  load_clutY;
    logic        load_is8bit;
    logic        invalidate;
    logic        ready;
    logic        busy;
    logic        load_done;

    logic        mem_req;
    logic [14:0] mem_addr;
    logic        mem_ack;
    logic        mem_dvalid;
    logic [31:0] mem_data;

    logic        clut_we;
    logic [6:0]  clut_waddr;
    logic [31:0] clut_wdata;

    modport slave (
        input  load_req, load_clutX, load_clutY, load_is8bit, invalidate,
        output ready, busy, load_done,
        output mem_req, mem_addr,
        input  mem_ack, mem_dvalid, mem_data,
        output clut_we, clut_waddr, clut_wdata
    );

    modport master (
        output load_req, load_clutX, load_clutY, load_is8bit, invalidate,
        input  ready, busy, load_done,
        input  mem_req, mem_addr,
        output mem_ack, mem_dvalid, mem_data,
        input  clut_we, clut_waddr, clut_wdata
    );
endinterface

// File: rtl/clut_cache_loader.sv
// Tagged CLUT cache refill sequencer: fetches 16 or 256 palette entries from VRAM in 16-pixel blocks.
// Optional hit/miss counters are compiled in when CLUT_LOADER_PERF_EN is defined.
module clut_cache_loader #(
    parameter int BEATS_PER_BLOCK = 8
) (
    input logic clk,
    input logic rst,
    clut_cache_loader_if.slave bus
`ifdef CLUT_LOADER_PERF_EN
    ,
    output logic [15:0] perf_hits,
    output logic [15:0] perf_misses
`endif
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] REQ  = 2'd1;
    localparam logic [1:0] DATA = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    localparam logic [2:0] LAST_BEAT = 3'(BEATS_PER_BLOCK - 1);

    logic [1:0]  state;
    logic        tagValid;
    logic        tagIs8bit;
    logic [5:0]  tagX;
    logic [8:0]  tagY;
    logic [5:0]  reqX;
    logic [8:0]  reqY;
    logic        reqIs8bit;
    logic [3:0]  blk;
    logic [2:0]  beat;
    logic        invSeen;
    logic        loadDone;
    logic        clutWe;
    logic [6:0]  clutWaddr;
    logic [31:0] clutWdata;

    logic        accept;
    logic        hit;
    logic        lastBlk;
    logic [5:0]  xBlk;

    // A same-cycle invalidate wins over the tag, and an 8-bit load covers 4-bit requests.
    assign accept  = (state == IDLE) && bus.load_req;
    assign hit     = tagValid && !bus.invalidate &&
                     (tagX == bus.load_clutX) && (tagY == bus.load_clutY) &&
                     (tagIs8bit || !bus.load_is8bit);
    assign lastBlk = (blk == (reqIs8bit ? 4'd15 : 4'd0));
    assign xBlk    = reqX + {2'b00, blk};

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            tagValid  <= 1'b0;
            tagIs8bit <= 1'b0;
            tagX      <= '0;
            tagY      <= '0;
            reqX      <= '0;
            reqY      <= '0;
            reqIs8bit <= 1'b0;
            blk       <= '0;
            beat      <= '0;
            invSeen   <= 1'b0;
            loadDone  <= 1'b0;
            clutWe    <= 1'b0;
            clutWaddr <= '0;
            clutWdata <= '0;
        end else begin
            loadDone <= 1'b0;
            clutWe   <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.invalidate) tagValid <= 1'b0;
                    if (bus.load_req) begin
                        if (hit) begin
                            loadDone <= 1'b1;
                        end else begin
                            reqX      <= bus.load_clutX;
                            reqY      <= bus.load_clutY;
                            reqIs8bit <= bus.load_is8bit;
                            blk       <= '0;
                            tagValid  <= 1'b0;
                            invSeen   <= 1'b0;
                            state     <= REQ;
                        end
                    end
                end
                REQ: begin
                    if (bus.mem_ack) begin
                        beat  <= '0;
                        state <= DATA;
                    end
                end
                DATA: begin
                    if (bus.mem_dvalid) begin
                        clutWe    <= 1'b1;
                        clutWaddr <= {blk, beat};
                        clutWdata <= bus.mem_data;
                        beat      <= beat + 3'd1;
                        if (beat == LAST_BEAT) begin
                            if (lastBlk) begin
                                state <= DONE;
                            end else begin
                                blk   <= blk + 4'd1;
                                state <= REQ;
                            end
                        end
                    end
                end
                DONE: begin
                    // The final pair is written this cycle, so the tag may now be published.
                    tagValid  <= !invSeen && !bus.invalidate;
                    tagX      <= reqX;
                    tagY      <= reqY;
                    tagIs8bit <= reqIs8bit;
                    loadDone  <= 1'b1;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
            if ((state != IDLE) && bus.invalidate) invSeen <= 1'b1;
        end
    end

    assign bus.ready      = (state == IDLE);
    assign bus.busy       = (state != IDLE);
    assign bus.load_done  = loadDone;
    assign bus.mem_req    = (state == REQ);
    assign bus.mem_addr   = {reqY, xBlk};
    assign bus.clut_we    = clutWe;
    assign bus.clut_waddr = clutWaddr;
    assign bus.clut_wdata = clutWdata;

`ifdef CLUT_LOADER_PERF_EN
    logic [15:0] hitCount;
    logic [15:0] missCount;

    // Saturating counters, one event per accepted request.
    always_ff @(posedge clk) begin
        if (rst) begin
            hitCount  <= '0;
            missCount <= '0;
        end else if (accept) begin
            if (hit && (hitCount != 16'hFFFF)) hitCount <= hitCount + 16'd1;
            if (!hit && (missCount != 16'hFFFF)) missCount <= missCount + 16'd1;
        end
    end

    assign perf_hits   = hitCount;
    assign perf_misses = missCount;
`else
    logic unusedAccept;
    assign unusedAccept = accept;
`endif

endmodule
